// File: rtl/ser2par_pkg.sv
// Shared constants and helpers for the ser2par_stream deserialiser.
// Optional feature macro used by this block: SER2PAR_OVF_EN (overflow flag).
package ser2par_pkg;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  // Beat counter width; a 2-beat word still needs one counter bit.
  function automatic int cnt_width(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/ser2par_ostage.sv
// One-entry valid/ready holding register with drop-on-full decision.
// Overflow flag and its clear exist only when SER2PAR_OVF_EN is defined.
module ser2par_ostage
  import ser2par_pkg::*;
#(
  parameter int OW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          complete_i,
  input  logic [OW-1:0] word_i,
  input  logic          oready_i,
  input  logic          ovf_clear_i,
  output logic          ovalid_o,
  output logic [OW-1:0] odata_o,
  output logic          overflow_o
);

  // Handshake: a word transfers on ovalid_o & oready_i; while ovalid_o is high
  // and no transfer happens, odata_o is held stable and ovalid_o stays high.
  logic          ovalid_q, ovalid_d;
  logic [OW-1:0] odata_q, odata_d;
  logic          xfer, load;

  assign xfer = ovalid_q & oready_i;
  // Same-cycle transfer frees the slot, so the new word loads without a bubble.
  assign load = complete_i & (~ovalid_q | oready_i);

  always_comb begin
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    if (load) begin
      ovalid_d = 1'b1;
      odata_d  = word_i;
    end else if (xfer) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

  assign ovalid_o = ovalid_q;
  assign odata_o  = odata_q;

`ifdef SER2PAR_OVF_EN
  logic drop;
  logic ovf_q, ovf_d;

  assign drop = complete_i & ovalid_q & ~oready_i;

  // Set wins over a same-cycle clear so no drop event is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clear_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;
`else
  logic unused_ovf_clear;
  assign unused_ovf_clear = ovf_clear_i;
  assign overflow_o       = 1'b0;
`endif

endmodule

// File: rtl/ser2par_stream.sv
// IW-bit beats in, OW-bit words out: beat store, counter, sync and ordering.
// Define SER2PAR_OVF_EN to build the sticky overflow flag in the output stage.
module ser2par_stream
  import ser2par_pkg::*;
#(
  parameter int IW = 1,
  parameter int OW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          direct,
  input  logic          sync,
  input  logic          ivalid,
  input  logic [IW-1:0] idata,
  output logic          ovalid,
  input  logic          oready,
  output logic [OW-1:0] odata,
  output logic          overflow,
  input  logic          ovf_clear
);

  localparam int BEATS = OW / IW;
  localparam int CW    = cnt_width(BEATS);

  // Only the first BEATS-1 beats need storage; the last is taken straight from idata.
  logic [IW-1:0] slot_q [BEATS-1];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, last_beat, complete;
  logic [OW-1:0] word_d;
  logic [IW-1:0] beat_v;

  assign accept    = enable & ivalid;
  assign last_beat = (cnt_q == CW'(BEATS - 1));
  assign complete  = accept & ~sync & last_beat;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      if (sync) begin
        cnt_d = CW'(1);
      end else if (last_beat) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int k = 0; k < BEATS - 1; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        if (sync) begin
          slot_q[0] <= idata;
        end else begin
          for (int k = 0; k < BEATS - 1; k++) begin
            if (cnt_q == CW'(k)) begin
              slot_q[k] <= idata;
            end
          end
        end
      end
    end
  end

  // Ordering uses direct as seen on the completing beat only.
  always_comb begin
    word_d = '0;
    beat_v = '0;
    for (int k = 0; k < BEATS; k++) begin
      beat_v = (k == BEATS - 1) ? idata : slot_q[k];
      if (direct == DIR_MSB_FIRST) begin
        word_d[(BEATS-1-k)*IW +: IW] = beat_v;
      end else begin
        word_d[k*IW +: IW] = beat_v;
      end
    end
  end

  ser2par_ostage #(
    .OW(OW)
  ) u_ostage (
    .clock       (clock),
    .reset       (reset),
    .complete_i  (complete),
    .word_i      (word_d),
    .oready_i    (oready),
    .ovf_clear_i (ovf_clear),
    .ovalid_o    (ovalid),
    .odata_o     (odata),
    .overflow_o  (overflow)
  );

endmodule

// File: tb/tb_ser2par_stream.sv
// Directed bench for ser2par_stream with IW=2, OW=8 (four beats per word).
// Overflow expectations follow SER2PAR_OVF_EN.
module tb_ser2par_stream;

  localparam int IW = 2;
  localparam int OW = 8;
`ifdef SER2PAR_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, enable, direct, sync, ivalid, oready, ovf_clear;
  logic [IW-1:0] idata;
  logic          ovalid, overflow;
  logic [OW-1:0] odata;

  logic [OW-1:0] exp_q [$];
  int            n_vec = 0;
  int            n_err = 0;

  ser2par_stream #(.IW(IW), .OW(OW)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .direct    (direct),
    .sync      (sync),
    .ivalid    (ivalid),
    .idata     (idata),
    .ovalid    (ovalid),
    .oready    (oready),
    .odata     (odata),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag);
    logic [OW-1:0] w;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed no expected word queued, expected one", tag);
    end else begin
      w = exp_q.pop_front();
      chk({tag, "_valid"}, {31'd0, ovalid}, 32'd1);
      chk({tag, "_data"}, {24'd0, odata}, {24'd0, w});
    end
  endtask

  // drivers: inputs change 1 time unit after the rising edge
  task automatic beat(input logic [IW-1:0] d, input logic s);
    ivalid = 1'b1;
    idata  = d;
    sync   = s;
    @(posedge clock);
    #1;
    ivalid = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic word4(input logic [IW-1:0] b0, input logic [IW-1:0] b1,
                       input logic [IW-1:0] b2, input logic [IW-1:0] b3);
    beat(b0, 1'b0);
    beat(b1, 1'b0);
    beat(b2, 1'b0);
    beat(b3, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; direct = 1'b0; sync = 1'b0; ivalid = 1'b0;
    idata = '0; oready = 1'b1; ovf_clear = 1'b0;
    #12;
    chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
    chk("rst_odata", {24'd0, odata}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(1);

    // LSB-first: beats 01,10,11,00 -> 0x39
    beat(2'b01, 1'b0); beat(2'b10, 1'b0); beat(2'b11, 1'b0);
    chk("lsb_no_early", {31'd0, ovalid}, 32'd0);
    beat(2'b00, 1'b0);
    exp_q.push_back(8'h39);
    chk_word("lsb");
    idle(1);
    chk("lsb_drop_valid", {31'd0, ovalid}, 32'd0);

    // MSB-first: same beats -> 0x6C
    direct = 1'b1;
    word4(2'b01, 2'b10, 2'b11, 2'b00);
    exp_q.push_back(8'h6C);
    chk_word("msb");
    idle(1);

    // direct only matters on the completing beat
    beat(2'b01, 1'b0); beat(2'b10, 1'b0); beat(2'b11, 1'b0);
    direct = 1'b0;
    beat(2'b00, 1'b0);
    exp_q.push_back(8'h39);
    chk_word("dir_last");
    idle(1);

    // sync re-align: 01,10,(sync)11,00,01,10 -> beats 11,00,01,10 -> 0x93
    beat(2'b01, 1'b0); beat(2'b10, 1'b0); beat(2'b11, 1'b1); beat(2'b00, 1'b0);
    chk("sync_no_word", {31'd0, ovalid}, 32'd0);
    beat(2'b01, 1'b0); beat(2'b10, 1'b0);
    exp_q.push_back(8'h93);
    chk_word("sync");
    idle(1);

    // enable low freezes assembly
    beat(2'b01, 1'b0); beat(2'b10, 1'b0);
    enable = 1'b0;
    beat(2'b11, 1'b0); beat(2'b11, 1'b0);
    chk("en_frozen", {31'd0, ovalid}, 32'd0);
    enable = 1'b1;
    beat(2'b11, 1'b0); beat(2'b00, 1'b0);
    exp_q.push_back(8'h39);
    chk_word("enable");
    idle(1);

    // overflow: hold 0x39, drop 0x6C
    oready = 1'b0;
    word4(2'b01, 2'b10, 2'b11, 2'b00);
    exp_q.push_back(8'h39);
    chk_word("ovf_first");
    chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
    direct = 1'b1;
    word4(2'b01, 2'b10, 2'b11, 2'b00);
    direct = 1'b0;
    exp_q.push_back(8'h39);
    chk_word("ovf_held");
    chk("ovf_set", {31'd0, overflow}, {31'd0, EXP_OVF});
    oready = 1'b1;
    idle(1);
    chk("ovf_drained", {31'd0, ovalid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, {31'd0, EXP_OVF});
    ovf_clear = 1'b1;
    idle(1);
    ovf_clear = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // set wins over same-cycle clear
    oready = 1'b0;
    word4(2'b01, 2'b10, 2'b11, 2'b00);
    beat(2'b00, 1'b0); beat(2'b11, 1'b0); beat(2'b10, 1'b0);
    ovf_clear = 1'b1;
    beat(2'b01, 1'b0);
    ovf_clear = 1'b0;
    chk("set_wins", {31'd0, overflow}, {31'd0, EXP_OVF});
    exp_q.push_back(8'h39);
    chk_word("set_wins_held");

    // word completes in the transfer cycle: held 0x39 leaves, 0xE4 loads, no bubble
    beat(2'b00, 1'b0); beat(2'b01, 1'b0); beat(2'b10, 1'b0);
    oready = 1'b1;
    beat(2'b11, 1'b0);
    exp_q.push_back(8'hE4);
    chk_word("b2b");
    idle(1);
    chk("b2b_after", {31'd0, ovalid}, 32'd0);
    ovf_clear = 1'b1;
    idle(1);
    ovf_clear = 1'b0;

    // continuous stream with oready=1
    word4(2'b01, 2'b10, 2'b11, 2'b00);
    exp_q.push_back(8'h39);
    chk_word("stream_w0");
    beat(2'b00, 1'b0);
    chk("stream_gap", {31'd0, ovalid}, 32'd0);
    beat(2'b01, 1'b0); beat(2'b10, 1'b0); beat(2'b11, 1'b0);
    exp_q.push_back(8'hE4);
    chk_word("stream_w1");

    // asynchronous reset with a held word, overflow and a partial frame
    oready = 1'b0;
    word4(2'b01, 2'b10, 2'b11, 2'b00);
    word4(2'b01, 2'b10, 2'b11, 2'b00);
    beat(2'b01, 1'b0); beat(2'b10, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ovalid", {31'd0, ovalid}, 32'd0);
    chk("arst_odata", {24'd0, odata}, 32'd0);
    chk("arst_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    oready = 1'b1;
    idle(1);
    beat(2'b01, 1'b0); beat(2'b10, 1'b0); beat(2'b11, 1'b0);
    chk("arst_no_early", {31'd0, ovalid}, 32'd0);
    beat(2'b00, 1'b0);
    exp_q.push_back(8'h39);
    chk_word("arst_word");
    idle(2);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
